// File: rtl/apb_exe_regs_if.sv
// APB bus bundle between a requester and the apb_exe_regs register block.
interface apb_exe_regs_if;
  logic        i_psel;
  logic        i_penable;
  logic        i_pwrite;
  logic [4:0]  i_paddr;
  logic [31:0] i_pwdata;
  logic [31:0] o_prdata;
  logic        o_pready;
  logic        o_pslverr;

  modport master (
    output i_psel, i_penable, i_pwrite, i_paddr, i_pwdata,
    input  o_prdata, o_pready, o_pslverr
  );

  modport slave (
    input  i_psel, i_penable, i_pwrite, i_paddr, i_pwdata,
    output o_prdata, o_pready, o_pslverr
  );
endinterface

// File: rtl/apb_exe_regs.sv
// APB register front-end for an execution unit: operands, launch control, status and result,
// with a watchdog that aborts an operation the unit never completes.
module apb_exe_regs #(
  parameter int unsigned BITS    = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                   i_clk,
  input  logic                   i_rsn,
  apb_exe_regs_if.slave          apb,
  output logic        [BITS-1:0] o_argA,
  output logic signed [BITS-1:0] o_argB,
  output logic        [2:0]      o_oper,
  output logic                   o_start,
  input  logic        [BITS-1:0] i_result,
  input  logic                   i_error,
  input  logic                   i_done
);

  localparam int unsigned      CntW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0]  CntMax = CntW'(TIMEOUT);

  localparam logic [4:0] AddrArgA   = 5'h00;
  localparam logic [4:0] AddrArgB   = 5'h04;
  localparam logic [4:0] AddrCtrl   = 5'h08;
  localparam logic [4:0] AddrStatus = 5'h0C;
  localparam logic [4:0] AddrResult = 5'h10;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q;
  logic [BITS-1:0] arg_a_q;
  logic [BITS-1:0] arg_b_q;
  logic [BITS-1:0] result_q;
  logic [2:0]      oper_q;
  logic            done_q;
  logic            error_q;
  logic            timeout_q;
  logic            start_q;
  logic [CntW-1:0] cnt_q;

  logic        busy;
  logic        access;
  logic        addr_hit;
  logic        addr_ro;
  logic        slverr;
  logic        wr_en;
  logic [31:0] rdata;
  logic        unused_pwdata;

  assign busy   = (state_q == StBusy);
  // Gating with reset keeps the bus outputs at 0 while reset is held.
  assign access = i_rsn & apb.i_psel & apb.i_penable;

  always_comb begin
    rdata    = '0;
    addr_hit = 1'b1;
    addr_ro  = 1'b0;
    case (apb.i_paddr)
      AddrArgA:   rdata = 32'(arg_a_q);
      AddrArgB:   rdata = 32'(arg_b_q);
      AddrCtrl:   rdata = {29'b0, oper_q};
      AddrStatus: begin
        rdata   = {28'b0, timeout_q, error_q, done_q, busy};
        addr_ro = 1'b1;
      end
      AddrResult: begin
        rdata   = 32'(result_q);
        addr_ro = 1'b1;
      end
      default:    addr_hit = 1'b0;
    endcase
  end

  // Writable registers are locked while an operation is in flight.
  assign slverr = ~addr_hit | (apb.i_pwrite & (addr_ro | busy));
  assign wr_en  = access & apb.i_pwrite & ~slverr;

  assign apb.o_pready  = access;
  assign apb.o_pslverr = access & slverr;
  assign apb.o_prdata  = (access & ~apb.i_pwrite & ~slverr) ? rdata : '0;

  assign unused_pwdata = ^apb.i_pwdata;

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      state_q   <= StIdle;
      arg_a_q   <= '0;
      arg_b_q   <= '0;
      result_q  <= '0;
      oper_q    <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
      start_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      start_q <= 1'b0;
      if (wr_en) begin
        case (apb.i_paddr)
          AddrArgA: arg_a_q <= apb.i_pwdata[BITS-1:0];
          AddrArgB: arg_b_q <= apb.i_pwdata[BITS-1:0];
          AddrCtrl: begin
            oper_q <= apb.i_pwdata[2:0];
            if (apb.i_pwdata[8]) begin
              start_q   <= 1'b1;
              done_q    <= 1'b0;
              error_q   <= 1'b0;
              timeout_q <= 1'b0;
              cnt_q     <= '0;
              state_q   <= StBusy;
            end
          end
          default: ;
        endcase
      end
      if (state_q == StBusy) begin
        // A completion in the watchdog's final cycle still wins.
        if (i_done) begin
          result_q <= i_result;
          error_q  <= i_error;
          done_q   <= 1'b1;
          state_q  <= StIdle;
        end else if (cnt_q == CntMax) begin
          timeout_q <= 1'b1;
          error_q   <= 1'b1;
          done_q    <= 1'b1;
          state_q   <= StIdle;
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end
    end
  end

  assign o_argA  = arg_a_q;
  assign o_argB  = $signed(arg_b_q);
  assign o_oper  = oper_q;
  assign o_start = start_q;

endmodule

// File: tb/tb_apb_exe_regs.sv
// Randomized bench for apb_exe_regs: a behavioural register/operation model predicts every
// read and error response; a responder emulates the execution unit with a chosen latency.
module tb_apb_exe_regs;
  localparam int unsigned BITS    = 4;
  localparam int unsigned TIMEOUT = 15;
  localparam logic [31:0] Mask    = (32'd1 << BITS) - 32'd1;

  logic            clk;
  logic            rsn;
  logic [BITS-1:0] arg_a;
  logic [BITS-1:0] arg_b;
  logic [2:0]      oper;
  logic            start;
  logic [BITS-1:0] result;
  logic            error;
  logic            done;

  apb_exe_regs_if bus ();

  apb_exe_regs #(.BITS(BITS), .TIMEOUT(TIMEOUT)) dut (
    .i_clk    (clk),
    .i_rsn    (rsn),
    .apb      (bus),
    .o_argA   (arg_a),
    .o_argB   (arg_b),
    .o_oper   (oper),
    .o_start  (start),
    .i_result (result),
    .i_error  (error),
    .i_done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] m_arg_a, m_arg_b, m_oper, m_result;
  logic        m_busy, m_done, m_err, m_to;
  logic [31:0] p_result;
  logic        p_done, p_err, p_to;
  int          busy_len;

  // Execution-unit responder: i_done comes resp_delay cycles after the o_start cycle.
  int          resp_delay = -1;
  int          cd = -1;
  logic [31:0] resp_result = '0;
  logic        resp_error = 1'b0;

  initial begin
    done   = 1'b0;
    result = '0;
    error  = 1'b0;
    forever begin
      @(negedge clk);
      done = 1'b0;
      if (start === 1'b1) cd = resp_delay;
      else if (cd > 0) cd--;
      if (cd == 0) begin
        done   = 1'b1;
        result = resp_result[BITS-1:0];
        error  = resp_error;
        cd     = -1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  function automatic logic mapped(input logic [4:0] a);
    return (a == 5'h00) || (a == 5'h04) || (a == 5'h08) || (a == 5'h0C) || (a == 5'h10);
  endfunction

  function automatic logic [31:0] model_rdata(input logic [4:0] a);
    case (a)
      5'h00:   return m_arg_a;
      5'h04:   return m_arg_b;
      5'h08:   return m_oper;
      5'h0C:   return m_busy ? 32'h1 : {28'b0, m_to, m_err, m_done, 1'b0};
      5'h10:   return m_result;
      default: return 32'h0;
    endcase
  endfunction

  task automatic apb_xfer(input logic wr, input logic [4:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic err);
    @(posedge clk); #1;
    bus.i_psel    = 1'b1;
    bus.i_penable = 1'b0;
    bus.i_pwrite  = wr;
    bus.i_paddr   = a;
    bus.i_pwdata  = d;
    @(negedge clk);
    check_eq("pready_setup", {31'b0, bus.o_pready}, 32'h0);
    @(posedge clk); #1;
    bus.i_penable = 1'b1;
    @(negedge clk);
    check_eq("pready_access", {31'b0, bus.o_pready}, 32'h1);
    rd  = bus.o_prdata;
    err = bus.o_pslverr;
    @(posedge clk); #1;
    bus.i_psel    = 1'b0;
    bus.i_penable = 1'b0;
    bus.i_pwrite  = 1'b0;
  endtask

  task automatic read_check(input logic [4:0] a, input string tag);
    logic [31:0] rd;
    logic        err;
    apb_xfer(1'b0, a, 32'h0, rd, err);
    check_eq({tag, "_rdata"}, rd, model_rdata(a));
    check_eq({tag, "_rd_slverr"}, {31'b0, err}, {31'b0, ~mapped(a)});
  endtask

  task automatic write_check(input logic [4:0] a, input logic [31:0] d, input string tag);
    logic [31:0] rd;
    logic        err;
    logic        exp_err;
    exp_err = !mapped(a) || (a == 5'h0C) || (a == 5'h10) || m_busy;
    apb_xfer(1'b1, a, d, rd, err);
    check_eq({tag, "_wr_slverr"}, {31'b0, err}, {31'b0, exp_err});
    if (!exp_err) begin
      if (a == 5'h00) m_arg_a = d & Mask;
      if (a == 5'h04) m_arg_b = d & Mask;
      if (a == 5'h08) m_oper  = d & 32'h7;
    end
  endtask

  task automatic start_op(input logic [2:0] op, input int d, input logic [31:0] r,
                          input logic e);
    logic [31:0] rd;
    logic        err;
    resp_delay  = d;
    resp_result = r;
    resp_error  = e;
    apb_xfer(1'b1, 5'h08, 32'h100 | 32'(op), rd, err);
    check_eq("start_slverr", {31'b0, err}, 32'h0);
    check_eq("start_pulse_hi", {31'b0, start}, 32'h1);
    m_oper = 32'(op);
    m_busy = 1'b1;
    p_done = 1'b1;
    if (d >= 0 && d <= int'(TIMEOUT)) begin
      busy_len = d + 1;
      p_err    = e;
      p_to     = 1'b0;
      p_result = r & Mask;
    end else begin
      busy_len = int'(TIMEOUT) + 1;
      p_err    = 1'b1;
      p_to     = 1'b1;
      p_result = m_result;
    end
    @(posedge clk); #1;
    check_eq("start_pulse_lo", {31'b0, start}, 32'h0);
    check_eq("argA_out", 32'(arg_a), m_arg_a);
    check_eq("argB_out", 32'(arg_b), m_arg_b);
    check_eq("oper_out", 32'(oper), m_oper);
  endtask

  task automatic finish_op(input string tag);
    logic [31:0] rd;
    logic        err;
    int          polls;
    polls = 0;
    do begin
      apb_xfer(1'b0, 5'h0C, 32'h0, rd, err);
      polls++;
    end while (rd[0] && polls < 40);
    check_eq({tag, "_busy_clears"}, {31'b0, rd[0]}, 32'h0);
    m_busy   = 1'b0;
    m_done   = p_done;
    m_err    = p_err;
    m_to     = p_to;
    m_result = p_result;
    read_check(5'h0C, {tag, "_status"});
    read_check(5'h10, {tag, "_result"});
    repeat (6) @(posedge clk);
    read_check(5'h0C, {tag, "_status_late"});
    read_check(5'h10, {tag, "_result_late"});
  endtask

  // The mid-operation STATUS read lands in BUSY cycle 3+w counted from the o_start cycle.
  task automatic run_op(input logic [2:0] op, input int d, input logic [31:0] r,
                        input logic e, input int w, input string tag);
    logic [31:0] rd;
    logic        err;
    logic [31:0] exp_mid;
    start_op(op, d, r, e);
    repeat (w) @(posedge clk);
    apb_xfer(1'b0, 5'h0C, 32'h0, rd, err);
    exp_mid = (3 + w < busy_len) ? 32'h1 : {28'b0, p_to, p_err, p_done, 1'b0};
    check_eq({tag, "_status_mid"}, rd, exp_mid);
    finish_op(tag);
  endtask

  task automatic model_reset();
    m_arg_a  = '0;
    m_arg_b  = '0;
    m_oper   = '0;
    m_result = '0;
    m_busy   = 1'b0;
    m_done   = 1'b0;
    m_err    = 1'b0;
    m_to     = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_pready"}, {31'b0, bus.o_pready}, 32'h0);
    check_eq({tag, "_pslverr"}, {31'b0, bus.o_pslverr}, 32'h0);
    check_eq({tag, "_prdata"}, bus.o_prdata, 32'h0);
    check_eq({tag, "_start"}, {31'b0, start}, 32'h0);
  endtask

  initial begin
    logic [4:0]  addrs [5];
    logic [31:0] rd;
    logic        err;
    addrs = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10};

    model_reset();
    rsn           = 1'b0;
    bus.i_psel    = 1'b1;
    bus.i_penable = 1'b1;
    bus.i_pwrite  = 1'b0;
    bus.i_paddr   = 5'h14;
    bus.i_pwdata  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    bus.i_psel    = 1'b0;
    bus.i_penable = 1'b0;
    rsn           = 1'b1;

    for (int i = 0; i < 5; i++) read_check(addrs[i], "reset_regs");

    // Basic operation
    write_check(5'h00, 32'h5, "basic_a");
    write_check(5'h04, 32'h1, "basic_b");
    run_op(3'd3, 3, 32'h7, 1'b0, 0, "basic");

    // Error propagation
    write_check(5'h04, 32'h4, "err_b");
    run_op(3'd1, 5, 32'h3, 1'b1, 1, "errprop");

    // Timeout: i_done never comes
    run_op(3'd2, -1, 32'h0, 1'b0, int'(TIMEOUT) - 3, "timeout");

    // i_done in the same cycle the counter reaches TIMEOUT
    run_op(3'd4, int'(TIMEOUT), 32'hB, 1'b0, int'(TIMEOUT) - 3, "simul");

    // Late i_done after a timeout must be ignored
    run_op(3'd5, int'(TIMEOUT) + 2, 32'h9, 1'b0, 0, "late_done");

    // Bus errors
    read_check(5'h14, "unmapped_rd");
    write_check(5'h14, 32'h1, "unmapped_wr");
    write_check(5'h10, 32'hA, "result_wr");
    read_check(5'h10, "result_wr_after");
    write_check(5'h0C, 32'hF, "status_wr");
    read_check(5'h0C, "status_wr_after");
    start_op(3'd6, -1, 32'h0, 1'b0);
    write_check(5'h00, 32'h9, "busy_wr_a");
    check_eq("busy_argA_held", 32'(arg_a), m_arg_a);
    write_check(5'h08, 32'h101, "busy_wr_ctrl");
    check_eq("busy_oper_held", 32'(oper), m_oper);
    finish_op("busy_wr");

    // CTRL write without START only updates oper
    write_check(5'h08, 32'h5, "ctrl_nostart");
    @(negedge clk);
    check_eq("ctrl_nostart_pulse", {31'b0, start}, 32'h0);
    read_check(5'h08, "ctrl_nostart_oper");
    read_check(5'h0C, "ctrl_nostart_status");

    // Randomized mix against the model
    for (int it = 0; it < 120; it++) begin
      int          kind;
      logic [4:0]  a;
      logic [31:0] d;
      kind = int'($urandom_range(0, 9));
      a    = ($urandom_range(0, 5) == 5) ? 5'($urandom) : addrs[$urandom_range(0, 4)];
      if (kind < 4) begin
        d = $urandom;
        if (a == 5'h08) d[8] = 1'b0;
        write_check(a, d, "rnd");
      end else if (kind < 7) begin
        read_check(a, "rnd");
      end else begin
        int dly;
        dly = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TIMEOUT + 3));
        run_op(3'($urandom), dly, $urandom, 1'($urandom), int'($urandom_range(0, 18)),
               "rnd_op");
      end
    end

    // Reset in the middle of an operation; its i_done then arrives while idle
    write_check(5'h00, 32'h6, "mid_a");
    write_check(5'h04, 32'h3, "mid_b");
    start_op(3'd7, 8, 32'hC, 1'b1);
    repeat (2) @(posedge clk);
    #3;
    rsn           = 1'b0;
    bus.i_psel    = 1'b1;
    bus.i_penable = 1'b1;
    bus.i_pwrite  = 1'b0;
    bus.i_paddr   = 5'h00;
    #2;
    check_reset_outputs("midrst");
    check_eq("midrst_argA", 32'(arg_a), 32'h0);
    @(negedge clk);
    bus.i_psel    = 1'b0;
    bus.i_penable = 1'b0;
    rsn           = 1'b1;
    model_reset();
    repeat (15) @(posedge clk);
    for (int i = 0; i < 5; i++) read_check(addrs[i], "midrst_regs");
    check_eq("midrst_argB", 32'(arg_b), 32'h0);
    check_eq("midrst_oper", 32'(oper), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
